// File: rtl/exp_update_pipe.sv
`default_nettype none
// ============================================================================
// Module      : exp_update_pipe
// Description : Two-stage exponent-update pipeline for the FP multiplier.
//               Stage 1 forms the biased product exponent ex+ey-BIAS.
//               Stage 2 applies the LZA left-shift and the normalise/round
//               carries, then classifies the result as overflow (infinity),
//               underflow (denormal shift or flush-to-zero) or normal.
//               Valid/ready handshake, 2-cycle latency, full throughput.
// Ports       : clk, rst_n        clock / async active-low reset
//               flush             synchronous clear of in-flight operations
//               in_valid/in_ready input handshake
//               ex, ey            biased operand exponents
//               lza_shift         normaliser left-shift amount
//               ovf, ovf_rnd      mantissa overflow / rounding carry (+1 each)
//               in_tag/out_tag    sideband carried with the operation
//               out_valid/out_ready output handshake
//               ez                biased result exponent
//               mant_rshift       denormalising right-shift (underflow only)
//               ovf_flag, unf_flag, flush_zero  result classification
// Revision    : 1.0 - initial release
// ============================================================================
module exp_update_pipe #(
    parameter int EXP_W   = 8,
    parameter int SHIFT_W = 5,
    parameter int BIAS    = 127,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W-1:0]   ex,
    input  logic [EXP_W-1:0]   ey,
    input  logic [SHIFT_W-1:0] lza_shift,
    input  logic               ovf,
    input  logic               ovf_rnd,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   ez,
    output logic [SHIFT_W-1:0] mant_rshift,
    output logic               ovf_flag,
    output logic               unf_flag,
    output logic               flush_zero,
    output logic [TAG_W-1:0]   out_tag
);

    // Two guard bits: one for the ex+ey carry, one for the sign.
    localparam int IW = EXP_W + 2;

    localparam logic signed [IW-1:0] C_BIAS   = IW'(BIAS);
    localparam logic signed [IW-1:0] C_EMAX   = IW'(2**EXP_W - 1);
    localparam logic signed [IW-1:0] C_ONE    = IW'(1);
    localparam logic signed [IW-1:0] C_RS_MAX = IW'(2**SHIFT_W - 1);

    // Stage 1 registers
    logic                     v1_q;
    logic signed [IW-1:0]     e1_q;
    logic [SHIFT_W-1:0]       sh1_q;
    logic                     ovf1_q;
    logic                     rnd1_q;
    logic [TAG_W-1:0]         tag1_q;

    // Output stage registers
    logic                     v2_q;
    logic [EXP_W-1:0]         ez_q;
    logic [SHIFT_W-1:0]       rshift_q;
    logic                     ovf_flag_q;
    logic                     unf_flag_q;
    logic                     fz_q;
    logic [TAG_W-1:0]         tag2_q;

    // Handshake
    logic w_en1;
    logic w_en2;
    logic w_accept;
    logic w_ld2;

    assign w_en2    = ~v2_q | out_ready;
    assign w_en1    = ~v1_q | w_en2;
    assign in_ready = w_en1 & ~flush;
    assign w_accept = in_valid & in_ready;
    // Output data registers are frozen while flushing.
    assign w_ld2    = w_en2 & v1_q & ~flush;

    // Arithmetic
    logic signed [IW-1:0] w_e1;
    logic signed [IW-1:0] w_e2;
    logic signed [IW-1:0] w_d;

    assign w_e1 = $signed({2'b00, ex}) + $signed({2'b00, ey}) - C_BIAS;
    assign w_e2 = e1_q
                - $signed({{(IW-SHIFT_W){1'b0}}, sh1_q})
                + $signed({{(IW-1){1'b0}}, ovf1_q})
                + $signed({{(IW-1){1'b0}}, rnd1_q});
    assign w_d  = C_ONE - w_e2;

    // Classification (next-state of output stage)
    logic [EXP_W-1:0]   ez_d;
    logic [SHIFT_W-1:0] rshift_d;
    logic               ovf_flag_d;
    logic               unf_flag_d;
    logic               fz_d;

    always_comb begin
        ez_d       = '0;
        rshift_d   = '0;
        ovf_flag_d = 1'b0;
        unf_flag_d = 1'b0;
        fz_d       = 1'b0;
        if (w_e2 >= C_EMAX) begin
            ez_d       = '1;
            ovf_flag_d = 1'b1;
        end else if (w_e2 <= $signed(IW'(0))) begin
            // Zero or negative exponent: denormalise by 1 - e2.
            unf_flag_d = 1'b1;
            if (w_d <= C_RS_MAX) begin
                rshift_d = w_d[SHIFT_W-1:0];
            end else begin
                rshift_d = '1;
                fz_d     = 1'b1;
            end
        end else begin
            ez_d = w_e2[EXP_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            e1_q       <= '0;
            sh1_q      <= '0;
            ovf1_q     <= 1'b0;
            rnd1_q     <= 1'b0;
            tag1_q     <= '0;
            v2_q       <= 1'b0;
            ez_q       <= '0;
            rshift_q   <= '0;
            ovf_flag_q <= 1'b0;
            unf_flag_q <= 1'b0;
            fz_q       <= 1'b0;
            tag2_q     <= '0;
        end else begin
            if (flush) begin
                v1_q <= 1'b0;
                v2_q <= 1'b0;
            end else begin
                if (w_en1) v1_q <= w_accept;
                if (w_en2) v2_q <= v1_q;
            end
            if (w_accept) begin
                e1_q   <= w_e1;
                sh1_q  <= lza_shift;
                ovf1_q <= ovf;
                rnd1_q <= ovf_rnd;
                tag1_q <= in_tag;
            end
            if (w_ld2) begin
                ez_q       <= ez_d;
                rshift_q   <= rshift_d;
                ovf_flag_q <= ovf_flag_d;
                unf_flag_q <= unf_flag_d;
                fz_q       <= fz_d;
                tag2_q     <= tag1_q;
            end
        end
    end

    assign out_valid   = v2_q;
    assign ez          = ez_q;
    assign mant_rshift = rshift_q;
    assign ovf_flag    = ovf_flag_q;
    assign unf_flag    = unf_flag_q;
    assign flush_zero  = fz_q;
    assign out_tag     = tag2_q;

endmodule
`default_nettype wire
